// File: rtl/bcd_alu_seq_pkg.sv
// Shared opcodes, FSM encoding and width helper for the sequential BCD calculator.
package bcd_alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StConvIn,
        StExec,
        StConvOut,
        StDone
    } state_e;

    // Binary width able to hold the sum of two DIGITS-wide operands.
    function automatic int unsigned calc_bw(input int unsigned digits);
        return $clog2(10 ** digits) + 1;
    endfunction

endpackage

// File: rtl/bcd_dd_serial.sv
// Serial double-dabble: loads a binary value, then shifts it into BCD over BW cycles.
module bcd_dd_serial #(
    parameter int unsigned DIGITS = 5,
    parameter int unsigned BW     = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [BW-1:0]         value,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);
    localparam int unsigned CW = $clog2(BW + 1);

    logic [BW-1:0]       bin_q;
    logic [CW-1:0]       cnt_q;
    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q <= '0;
            cnt_q <= '0;
            bcd   <= '0;
            done  <= 1'b0;
        end else if (load) begin
            bin_q <= value;
            cnt_q <= CW'(BW);
            bcd   <= '0;
            done  <= 1'b0;
        end else if (cnt_q != '0) begin
            bcd   <= (4*DIGITS)'({adj, bin_q[BW-1]});
            bin_q <= bin_q << 1;
            cnt_q <= cnt_q - 1'b1;
            // Sticky until the next load so the controller can poll it.
            if (cnt_q == CW'(1)) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_alu_seq.sv
// Sequential BCD calculator: serial BCD->binary, one-cycle ALU, serial binary->BCD.
module bcd_alu_seq
    import bcd_alu_seq_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BW     = calc_bw(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    input  logic [2:0]            op,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result_bcd,
    output logic                  neg,
    output logic                  ovf,
    output logic                  err
);
    localparam int unsigned W = 4 * DIGITS;

    state_e              state;
    logic [W-1:0]        a_sh, b_sh;
    logic [2:0]          op_q;
    logic [BW-1:0]       a_acc, b_acc;
    logic [3:0]          cnt;
    logic                err_q, neg_q;

    logic [3:0]          a_dig, b_dig;
    logic [BW-1:0]       a_next, b_next;
    logic [BW-1:0]       exec_val;
    logic                exec_neg, exec_err;
    logic                accept, dd_load, dd_done;
    logic [4*(DIGITS+1)-1:0] dd_bcd;

    assign a_dig   = a_sh[W-1 -: 4];
    assign b_dig   = b_sh[W-1 -: 4];
    assign a_next  = (a_acc << 3) + (a_acc << 1) + BW'(a_dig);
    assign b_next  = (b_acc << 3) + (b_acc << 1) + BW'(b_dig);
    // A request arriving in the DONE cycle is taken on the edge that leaves DONE.
    assign accept  = start && (state == StIdle || state == StDone);
    assign dd_load = (state == StExec);

    always_comb begin
        exec_val = '0;
        exec_neg = 1'b0;
        exec_err = err_q;
        if (!err_q) begin
            case (op_q)
                OP_ADD: exec_val = a_acc + b_acc;
                OP_SUB: begin
                    if (a_acc >= b_acc) begin
                        exec_val = a_acc - b_acc;
                    end else begin
                        exec_val = b_acc - a_acc;
                        exec_neg = 1'b1;
                    end
                end
                OP_XOR: exec_val = a_acc ^ b_acc;
                OP_AND: exec_val = a_acc & b_acc;
                OP_OR:  exec_val = a_acc | b_acc;
                default: exec_err = 1'b1;
            endcase
        end
    end

    bcd_dd_serial #(
        .DIGITS (DIGITS + 1),
        .BW     (BW)
    ) u_dd (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (dd_load),
        .value (exec_val),
        .bcd   (dd_bcd),
        .done  (dd_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StIdle;
            a_sh       <= '0;
            b_sh       <= '0;
            op_q       <= '0;
            a_acc      <= '0;
            b_acc      <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            neg_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result_bcd <= '0;
            neg        <= 1'b0;
            ovf        <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: ;
                StConvIn: begin
                    a_acc <= a_next;
                    b_acc <= b_next;
                    a_sh  <= a_sh << 4;
                    b_sh  <= b_sh << 4;
                    cnt   <= cnt + 4'd1;
                    if (a_dig > 4'd9 || b_dig > 4'd9) begin
                        err_q <= 1'b1;
                    end
                    if (cnt == 4'(DIGITS - 1)) begin
                        state <= StExec;
                    end
                end
                StExec: begin
                    err_q <= exec_err;
                    neg_q <= exec_neg;
                    state <= StConvOut;
                end
                StConvOut: begin
                    if (dd_done) begin
                        result_bcd <= err_q ? '0 : dd_bcd[W-1:0];
                        ovf        <= !err_q && (dd_bcd[W +: 4] != 4'd0);
                        neg        <= !err_q && neg_q;
                        err        <= err_q;
                        done       <= 1'b1;
                        state      <= StDone;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
            if (accept) begin
                a_sh  <= a_bcd;
                b_sh  <= b_bcd;
                op_q  <= op;
                a_acc <= '0;
                b_acc <= '0;
                cnt   <= '0;
                err_q <= 1'b0;
                neg_q <= 1'b0;
                busy  <= 1'b1;
                state <= StConvIn;
            end
        end
    end

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Scoreboard bench for bcd_alu_seq with DIGITS=4: driver queues expectations, monitor checks on done.
module tb_bcd_alu_seq;
    import bcd_alu_seq_pkg::*;

    localparam int LAT = 21;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a_bcd = '0;
    logic [15:0] b_bcd = '0;
    logic [2:0]  op = '0;
    logic        busy, done, neg, ovf, err;
    logic [15:0] result_bcd;

    typedef struct {
        logic [15:0] res;
        logic        neg;
        logic        ovf;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [18:0] held = '0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    bcd_alu_seq #(.DIGITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_bcd      (a_bcd),
        .b_bcd      (b_bcd),
        .op         (op),
        .busy       (busy),
        .done       (done),
        .result_bcd (result_bcd),
        .neg        (neg),
        .ovf        (ovf),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop on done, otherwise outputs must hold the last completed result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc, e.due);
                    check("result_bcd", {16'd0, result_bcd}, {16'd0, e.res});
                    check("neg", {31'd0, neg}, {31'd0, e.neg});
                    check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                    check("err", {31'd0, err}, {31'd0, e.err});
                    check("busy_in_done", {31'd0, busy}, 32'd1);
                    held = {e.res, e.neg, e.ovf, e.err};
                end
            end else begin
                check("hold_outputs", {13'd0, result_bcd, neg, ovf, err}, {13'd0, held});
                if (sb.size() != 0 && cyc > sb[0].due) begin
                    check("done_timeout", cyc, sb[0].due);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic push_exp(input logic [15:0] r, input logic n, input logic v, input logic x);
        exp_t t;
        t.res = r; t.neg = n; t.ovf = v; t.err = x;
        t.due = cyc + 1 + LAT;
        sb.push_back(t);
    endtask

    task automatic scramble();
        a_bcd = 16'($urandom);
        b_bcd = 16'($urandom);
        op    = 3'($urandom);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                         input logic [15:0] r, input logic n, input logic v, input logic x);
        @(negedge clk);
        a_bcd = a; b_bcd = b; op = o; start = 1'b1;
        push_exp(r, n, v, x);
        @(negedge clk);
        start = 1'b0;
        scramble();
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_result"}, {16'd0, result_bcd}, 32'd0);
        check({tag, "_flags"}, {29'd0, neg, ovf, err}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        rst_n = 1'b1;

        issue(16'h1234, 16'h4321, OP_ADD, 16'h5555, 1'b0, 1'b0, 1'b0); drain();
        issue(16'h0005, 16'h0012, OP_SUB, 16'h0007, 1'b1, 1'b0, 1'b0); drain();
        issue(16'h0012, 16'h0005, OP_SUB, 16'h0007, 1'b0, 1'b0, 1'b0); drain();
        issue(16'h9999, 16'h9999, OP_SUB, 16'h0000, 1'b0, 1'b0, 1'b0); drain();
        issue(16'h9999, 16'h0001, OP_ADD, 16'h0000, 1'b0, 1'b1, 1'b0); drain();
        issue(16'h9999, 16'h6384, OP_OR,  16'h6383, 1'b0, 1'b1, 1'b0); drain();
        issue(16'h1234, 16'h4321, OP_XOR, 16'h5171, 1'b0, 1'b0, 1'b0); drain();
        issue(16'h1234, 16'h4321, OP_AND, 16'h0192, 1'b0, 1'b0, 1'b0); drain();
        issue(16'h12A4, 16'h0001, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b1); drain();
        issue(16'h1234, 16'h00F0, OP_SUB, 16'h0000, 1'b0, 1'b0, 1'b1); drain();
        issue(16'h1234, 16'h0001, 3'd6,   16'h0000, 1'b0, 1'b0, 1'b1); drain();
        issue(16'h0003, 16'h0001, 3'd7,   16'h0000, 1'b0, 1'b0, 1'b1); drain();

        // start pulsed while busy must be ignored
        issue(16'h4321, 16'h1234, OP_SUB, 16'h3087, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            start = ~start;
            a_bcd = 16'h1111; b_bcd = 16'h1111; op = OP_ADD;
        end
        @(negedge clk);
        start = 1'b0;
        drain();

        // back-to-back: second start raised in the done cycle
        issue(16'h0050, 16'h0050, OP_ADD, 16'h0100, 1'b0, 1'b0, 1'b0);
        begin
            int n = 0;
            while (!done && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("b2b_first_done_seen", {31'd0, done}, 32'd1);
            a_bcd = 16'h0999; b_bcd = 16'h0001; op = OP_ADD; start = 1'b1;
            push_exp(16'h1000, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            start = 1'b0;
            scramble();
        end
        drain();

        // reset during an operation discards it
        issue(16'h1111, 16'h2222, OP_ADD, 16'h3333, 1'b0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midop_reset");
        sb.delete();
        held = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        issue(16'h1111, 16'h2222, OP_ADD, 16'h3333, 1'b0, 1'b0, 1'b0); drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_alu_seq.md
# bcd_alu_seq

Sequential, parametrised BCD calculator core. It accepts two DIGITS-wide packed BCD operands and an opcode under a start/done handshake. It converts the operands to binary serially, executes add, sub, xor, and, or, then converts back with a multi-cycle double-dabble. The result is registered with sign, overflow and error flags. It sits between the keypad digit registers and the 7-segment display driver, and is the next-generation replacement for the combinational calculator datapath.

## Interface
Parameters:
- DIGITS, 4: operand and result width in BCD digits (1..8).
- BW, $clog2(10**DIGITS)+1: internal binary width. Derived; do not override.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request. Sampled only in IDLE.
- a_bcd  in  4*DIGITS  operand A, packed BCD, most significant digit in the top nibble.
- b_bcd  in  4*DIGITS  operand B, same format.
- op  in  3  opcode: ADD=0, SUB=1, XOR=2, AND=3, OR=4; 5..7 are invalid.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result fields are valid from this cycle on.
- result_bcd  out  4*DIGITS  result magnitude, packed BCD.
- neg  out  1  result is negative (SUB with A<B).
- ovf  out  1  true result exceeds 10^DIGITS-1.
- err  out  1  invalid opcode or a non-BCD nibble (>9) in A or B.

## Operation
- FSM states: IDLE, CONV_IN, EXEC, CONV_OUT, DONE.
- IDLE: on start=1, latch a_bcd, b_bcd and op, and go to CONV_IN.
- CONV_IN: runs for exactly DIGITS cycles, most significant digit first, both operands in parallel.
  - Per cycle: acc = acc*10 + digit, implemented as shifts plus adds.
  - Any nibble >9 sets a sticky internal err.
- EXEC: one cycle, BW-bit binary arithmetic.
  - ADD: A+B.
  - SUB: if A>=B then A-B with neg=0, else B-A with neg=1.
  - XOR, AND, OR: bitwise on the binary values.
  - Invalid op or sticky err: value 0, err=1.
- CONV_OUT: double dabble over exactly BW cycles into a (DIGITS+1)-digit shift register.
  - Each digit >=5 gets +3 before each shift.
- DONE: register the outputs and pulse done for one cycle.
  - result_bcd = low DIGITS digits.
  - ovf = top digit nonzero.
  - Return to IDLE.
- Bitwise results can exceed 10^DIGITS-1. ovf applies to them identically.
- When err=1: result_bcd=0, neg=0, ovf=0.
- result_bcd, neg, ovf and err are updated only in DONE. They hold their values through the next operation until its DONE.
- start while not in IDLE is ignored. There is no queueing.
- Input changes after acceptance have no effect.

## Timing
- Reset, when rst_n=0 at a clock edge:
  - state=IDLE.
  - busy=0, done=0.
  - result_bcd=0, neg=0, ovf=0, err=0.
  - All internal registers cleared.
- Reset takes priority over every other event, including mid-operation. A pending operation is discarded and no done is issued.
- Latency: start sampled at edge k, then done=1 during the cycle following edge k+DIGITS+BW+2. For DIGITS=4 (BW=15) that is 21 cycles.
- Latency is fixed and data-independent, including for the err case.
- busy=1 from edge k+1 until the edge that leaves DONE. done and busy are both high in the DONE cycle.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted at the next edge, once the FSM is back in IDLE.
- Minimum issue interval is DIGITS+BW+3 cycles.

## Structure
- Shared package or defines header holds:
  - Opcode constants: OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR.
  - FSM state encodings.
  - A helper for BW.
- Sub-module bcd_dd_serial: a serial double-dabble engine with load, BW-cycle shift, done flag and parametrised digit count. It is instantiated once.
- BCD-to-binary accumulation and EXEC stay in the top module.

## Test plan
All scenarios use DIGITS=4.
- Add: A=0x1234, B=0x4321, op=ADD → done at cycle 21; result_bcd=0x5555, neg=0, ovf=0, err=0.
- Negative subtract: A=0x0005, B=0x0012, op=SUB → result_bcd=0x0007, neg=1.
- Overflow:
  - A=0x9999, B=0x0001, op=ADD → result_bcd=0x0000, ovf=1.
  - A=0x9999, B=0x6384, op=OR → result_bcd=0x6383, ovf=1.
- Bitwise and error:
  - A=0x1234, B=0x4321, op=XOR → result_bcd=0x5171.
  - A=0x12A4, any op → err=1, result_bcd=0.
  - op=6 → err=1, result_bcd=0.
  - Latency still 21 cycles in the err cases.
- Handshake:
  - start pulsed repeatedly while busy → exactly one done; results unchanged until that done.
  - start asserted in the done cycle → second done 22 cycles later.
- Reset: rst_n=0 at cycle 10 of an ADD → next cycle all outputs 0, busy=0; no done follows. A new start afterwards completes normally.
